ccg_response_misr: RTL and testbench
====================================

// Module: ccg_response_misr
// PURPOSE
//  Downstream capture stage for the generated combinational circuits (CCGRC* family).
//  Accepts one response word (the f1..fN outputs) per pattern over a valid/ready handshake.
//  Compacts a fixed number of responses into a MISR signature.
//  Presents the signature for golden comparison and dataset labelling.
// PARAMETERS
//  WIDTH         19            response bits per pattern (f1..f19 -> in_resp[0..18]); WIDTH <= SIG_W
//  SIG_W         32            signature width
//  POLY          32'h04C11DB7  MISR feedback polynomial (x^SIG_W term implicit)
//  SEED          32'hFFFFFFFF  signature value loaded on start
//  NUM_PATTERNS  32            responses per run (2^5, exhaustive over x0..x4); >= 1
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-high reset
//  start      in   1                  begin a run (sampled in IDLE or DONE)
//  in_valid   in   1                  in_resp holds a valid response
//  in_ready   out  1                  stage can accept a response
//  in_resp    in   WIDTH              circuit response word
//  sig_ack    in   1                  consumer has taken the signature
//  sig_out    out  SIG_W              current / final signature
//  sig_valid  out  1                  sig_out is final
//  busy       out  1                  run in progress
//  pat_cnt    out  $clog2(NUM_PATTERNS+1)  responses accepted this run
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, sig_out=0, pat_cnt=0; in_ready, sig_valid, busy = 0.
//  FSM:
//   IDLE: start -> RUN; sig_out<=SEED; pat_cnt<=0.
//   RUN:  in_ready=1, busy=1. Accept when in_valid&&in_ready:
//         sig_out <= {sig_out[SIG_W-2:0],1'b0} ^ (sig_out[SIG_W-1] ? POLY : 0) ^ zero-extended in_resp;
//         pat_cnt++. The accept with pat_cnt==NUM_PATTERNS-1 -> DONE (next cycle).
//   DONE: sig_valid=1; sig_out and pat_cnt held.
//         sig_ack -> IDLE (sig_out retained, sig_valid drops).
//         start -> RUN, reseeded as from IDLE. start has priority over sig_ack when both asserted.
//  Registered: one update per accepted beat; no combinational in_valid->in_ready path.
//  in_valid outside RUN is ignored (in_ready=0), and in_resp is not sampled.
//  start while in RUN is ignored. sig_ack outside DONE is ignored.
//  No overflow: pat_cnt saturates at NUM_PATTERNS via the DONE transition.
//  Reset mid-run discards the partial signature and leaves no pending state.
// CONFIGURATION
//  CCG_MISR_GOLDEN_CMP_EN defined:
//   - adds port golden_sig (in, SIG_W) and port pass (out, 1).
//   - pass is registered on the DONE entry edge as (final signature == golden_sig).
//   - pass holds until the next start or rst; reset value 0.
//  Undefined: neither port exists; all other behaviour is identical.
// STRUCTURE
//  ccg_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} ccg_misr_state_t
//   - CCG_DEF_POLY and CCG_DEF_SEED constants
//   - function misr_step(sig, resp, poly)
//  Sub-module ccg_misr_core: signature register plus misr_step, with load/enable inputs.
//  The top level holds the FSM, the counter, the handshake and the optional compare.
// TESTING
//  1 SEED=0, NUM_PATTERNS=1: start, in_resp=19'h00001 -> DONE; sig_out=32'h00000001, pat_cnt=1.
//  2 SEED=32'h80000000, NUM_PATTERNS=1, in_resp=0 -> sig_out=32'h04C11DB7 (feedback path).
//  3 SEED=0, NUM_PATTERNS=2, in_resp=1 then 0, with in_valid gap cycles in between
//    -> sig_out=32'h00000002; no update on idle cycles.
//  4 Defaults: 32 responses driven through a golden model of the CCG circuit, x0..x4 = 0..31
//    -> sig_valid after the 32nd accept; sig_out matches the model.
//    With CCG_MISR_GOLDEN_CMP_EN: pass=1 against the correct golden, pass=0 with one bit flipped.
//  5 rst asserted after 10 accepts -> outputs 0 immediately (async).
//    Fresh start then gives the same signature as an uninterrupted run.
//  6 In DONE, start and sig_ack in the same cycle -> RUN with sig_out=SEED, pat_cnt=0.
//    start in RUN and in_valid in IDLE have no effect.

Source files
------------

// File: rtl/ccg_pkg.sv
// Shared types and constants for the CCG response MISR capture stage.
// misr_step is written over a 64-bit container so any SIG_W up to 64 can reuse it.
package ccg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ccg_misr_state_t;

  localparam logic [31:0] CCG_DEF_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CCG_DEF_SEED   = 32'hFFFFFFFF;
  localparam int unsigned CCG_MISR_MAX_W = 64;

  // One MISR clock: shift left, fold the bit that left the w-bit register back in
  // through poly, and XOR the zero-extended response. Bits at and above w are cleared.
  function automatic logic [63:0] misr_step(
    input logic [63:0] sig,
    input logic [63:0] resp,
    input logic [63:0] poly,
    input int unsigned w
  );
    logic [63:0] mask;
    logic        msb;
    logic [63:0] nxt;
    mask = (w >= CCG_MISR_MAX_W) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    msb  = |(sig & (64'd1 << (w - 32'd1)));
    nxt  = (sig << 1) ^ (msb ? poly : 64'd0) ^ resp;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/ccg_misr_core.sv
// Signature register for the response MISR: load seeds it, enable advances it
// by one misr_step on the presented response word.
module ccg_misr_core
  import ccg_pkg::*;
#(
  parameter int               WIDTH = 19,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(CCG_DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(CCG_DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_resp,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  assign w_next = SIG_W'(misr_step(64'(r_sig), 64'(i_resp), 64'(POLY), SIG_W));

  // Signature register; load takes priority over an update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end else begin
      r_sig <= r_sig;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/ccg_response_misr.sv
// Capture stage compacting NUM_PATTERNS circuit responses into a MISR signature.
// Optional golden compare (port golden_sig, output pass) under CCG_MISR_GOLDEN_CMP_EN.
module ccg_response_misr
  import ccg_pkg::*;
#(
  parameter int               WIDTH        = 19,
  parameter int               SIG_W        = 32,
  parameter logic [SIG_W-1:0] POLY         = SIG_W'(CCG_DEF_POLY),
  parameter logic [SIG_W-1:0] SEED         = SIG_W'(CCG_DEF_SEED),
  parameter int               NUM_PATTERNS = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      in_resp,
  input  logic                                  sig_ack,
  output logic [SIG_W-1:0]                      sig_out,
  output logic                                  sig_valid,
  output logic                                  busy,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]     pat_cnt
`ifdef CCG_MISR_GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0]                      golden_sig,
  output logic                                  pass
`endif
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);

  ccg_misr_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_valid;
  logic             r_busy;
  logic [SIG_W-1:0] w_sig;
  logic             w_load;
  logic             w_accept;
  logic             w_last;

  assign w_load   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = in_valid && r_ready && (r_state == RUN);
  assign w_last   = (r_cnt == CNT_W'(NUM_PATTERNS - 1));

`ifdef CCG_MISR_GOLDEN_CMP_EN
  logic             r_pass;
  logic [SIG_W-1:0] w_final;

  // The signature the final accept is about to write, compared on the DONE entry edge.
  assign w_final = SIG_W'(misr_step(64'(w_sig), 64'(in_resp), 64'(POLY), SIG_W));
  assign pass    = r_pass;
`endif

  ccg_misr_core #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_accept),
    .i_resp (in_resp),
    .o_sig  (w_sig)
  );

  // Run control: state, accepted-beat counter and registered handshake/status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
      r_pass  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
            r_pass  <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
`ifdef CCG_MISR_GOLDEN_CMP_EN
              r_pass  <= (w_final == golden_sig);
`endif
            end
          end
        end
        DONE: begin
          // A new start wins over a simultaneous acknowledge.
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
            r_pass  <= 1'b0;
`endif
          end else if (sig_ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
          r_pass  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign sig_valid = r_valid;
  assign busy      = r_busy;
  assign pat_cnt   = r_cnt;
  assign sig_out   = w_sig;

endmodule

// File: tb/tb_ccg_response_misr.sv
// Directed scoreboard bench for ccg_response_misr; four instances cover the
// small-seed corner configurations and the default 32-pattern run.
module tb_ccg_response_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] in_resp = 19'd0;
  logic        sig_ack = 1'b0;
  logic [31:0] golden_sig = 32'd0;

  logic        rdy_a, rdy_b, rdy_c, rdy_d;
  logic [31:0] sig_a, sig_b, sig_c, sig_d;
  logic        sv_a, sv_b, sv_c, sv_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic [0:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic [5:0]  cnt_d;
`ifdef CCG_MISR_GOLDEN_CMP_EN
  logic        pass_a, pass_b, pass_c, pass_d;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_def;

  always #5 clk = ~clk;

  ccg_response_misr #(.SEED(32'h00000000), .NUM_PATTERNS(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .in_resp(in_resp), .sig_ack(sig_ack), .sig_out(sig_a), .sig_valid(sv_a),
    .busy(busy_a), .pat_cnt(cnt_a)
`ifdef CCG_MISR_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .pass(pass_a)
`endif
  );
  ccg_response_misr #(.SEED(32'h80000000), .NUM_PATTERNS(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .in_resp(in_resp), .sig_ack(sig_ack), .sig_out(sig_b), .sig_valid(sv_b),
    .busy(busy_b), .pat_cnt(cnt_b)
`ifdef CCG_MISR_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .pass(pass_b)
`endif
  );
  ccg_response_misr #(.SEED(32'h00000000), .NUM_PATTERNS(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(rdy_c),
    .in_resp(in_resp), .sig_ack(sig_ack), .sig_out(sig_c), .sig_valid(sv_c),
    .busy(busy_c), .pat_cnt(cnt_c)
`ifdef CCG_MISR_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .pass(pass_c)
`endif
  );
  ccg_response_misr u_d (
    .clk(clk), .rst(rst), .start(start_d), .in_valid(in_valid), .in_ready(rdy_d),
    .in_resp(in_resp), .sig_ack(sig_ack), .sig_out(sig_d), .sig_valid(sv_d),
    .busy(busy_d), .pat_cnt(cnt_d)
`ifdef CCG_MISR_GOLDEN_CMP_EN
    , .golden_sig(golden_sig), .pass(pass_d)
`endif
  );

  // Stand-in for the generated combinational circuit: 19 outputs from x0..x4.
  function automatic logic [18:0] ccg_fn(input logic [4:0] x);
    return {x, x ^ 5'h15, x & {x[0], x[4:1]}, x[0] ^ x[1], x[2] | x[3], ^x, ~x[4]};
  endfunction

  // Bitwise reference MISR with the CRC-32 polynomial taps.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [18:0] r);
    logic [31:0] p;
    logic [31:0] rx;
    logic [31:0] n;
    p  = 32'h04C11DB7;
    rx = {13'd0, r};
    n[0] = (s[31] & p[0]) ^ rx[0];
    for (int i = 1; i < 32; i++) n[i] = s[i-1] ^ (s[31] & p[i]) ^ rx[i];
    return n;
  endfunction

  function automatic logic [31:0] ref_run();
    logic [31:0] s;
    s = 32'hFFFFFFFF;
    for (int x = 0; x < 32; x++) s = ref_step(s, ccg_fn(5'(x)));
    return s;
  endfunction

  function automatic logic [63:0] get_rdy(input int k);
    case (k)
      0: return 64'(rdy_a);
      1: return 64'(rdy_b);
      2: return 64'(rdy_c);
      default: return 64'(rdy_d);
    endcase
  endfunction

  function automatic logic [63:0] get_sv(input int k);
    case (k)
      0: return 64'(sv_a);
      1: return 64'(sv_b);
      2: return 64'(sv_c);
      default: return 64'(sv_d);
    endcase
  endfunction

  function automatic logic [63:0] get_sig(input int k);
    case (k)
      0: return 64'(sig_a);
      1: return 64'(sig_b);
      2: return 64'(sig_c);
      default: return 64'(sig_d);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int k);
    case (k)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      2: start_c = 1'b1;
      default: start_d = 1'b1;
    endcase
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
  endtask

  // Present one response and hold it until the target instance has taken it.
  task automatic send(input int k, input logic [18:0] r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_resp  = r;
    while (get_rdy(k) !== 64'd1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_ready_timeout", get_rdy(k), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int k, input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (get_sv(k) !== 64'd1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_sig_valid"}, get_sv(k), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sig_out"}, get_sig(k), 64'(e));
    end
  endtask

  initial begin
    exp_def = ref_run();
    repeat (2) tick();
    chk("reset_sig", 64'(sig_d), 64'd0);
    chk("reset_cnt", 64'(cnt_d), 64'd0);
    chk("reset_flags", 64'({rdy_d, sv_d, busy_d}), 64'd0);
    rst = 1'b0;
    tick();

    // Single pattern from a zero seed.
    exp_q.push_back(32'h00000001);
    do_start(0);
    chk("t1_busy", 64'(busy_a), 64'd1);
    send(0, 19'h00001);
    wait_done(0, "t1");
    chk("t1_cnt", 64'(cnt_a), 64'd1);

    // Feedback path from the top bit.
    exp_q.push_back(32'h04C11DB7);
    do_start(1);
    send(1, 19'h00000);
    wait_done(1, "t2");

    // Idle cycles between beats leave the signature alone.
    exp_q.push_back(32'h00000002);
    do_start(2);
    send(2, 19'h00001);
    repeat (3) begin
      tick();
      chk("t3_gap_sig", 64'(sig_c), 64'h1);
    end
    chk("t3_gap_cnt", 64'(cnt_c), 64'd1);
    send(2, 19'h00000);
    wait_done(2, "t3");
    chk("t3_cnt", 64'(cnt_c), 64'd2);

    // Full default run against the reference model.
    golden_sig = exp_def;
    exp_q.push_back(exp_def);
    do_start(3);
    chk("t4_seed", 64'(sig_d), 64'hFFFFFFFF);
    chk("t4_cnt0", 64'(cnt_d), 64'd0);
    for (int x = 0; x < 31; x++) send(3, ccg_fn(5'(x)));
    chk("t4_not_early", 64'(sv_d), 64'd0);
    send(3, ccg_fn(5'd31));
    wait_done(3, "t4");
    chk("t4_cnt", 64'(cnt_d), 64'd32);
`ifdef CCG_MISR_GOLDEN_CMP_EN
    chk("t4_pass", 64'(pass_d), 64'd1);
`endif
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;
    chk("t4_ack_sv", 64'(sv_d), 64'd0);
    chk("t4_ack_sig_kept", 64'(sig_d), 64'(exp_def));

    // Responses offered in IDLE are ignored.
    in_valid = 1'b1;
    in_resp  = 19'h7FFFF;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t6_idle_sig", 64'(sig_d), 64'(exp_def));
    chk("t6_idle_rdy", 64'(rdy_d), 64'd0);
    chk("t6_idle_cnt", 64'(cnt_d), 64'd32);

    // Start pulses inside RUN change nothing; a flipped golden fails the compare.
    golden_sig = exp_def ^ 32'h00000400;
    exp_q.push_back(exp_def);
    do_start(3);
    for (int x = 0; x < 32; x++) begin
      if (x == 5 || x == 17) start_d = 1'b1;
      send(3, ccg_fn(5'(x)));
      start_d = 1'b0;
    end
    wait_done(3, "t6_start_in_run");
`ifdef CCG_MISR_GOLDEN_CMP_EN
    chk("t4_pass_flipped", 64'(pass_d), 64'd0);
`endif

    // Start and acknowledge together in DONE: start wins.
    start_d = 1'b1;
    sig_ack = 1'b1;
    tick();
    start_d = 1'b0;
    sig_ack = 1'b0;
    chk("t6_restart_sig", 64'(sig_d), 64'hFFFFFFFF);
    chk("t6_restart_cnt", 64'(cnt_d), 64'd0);
    chk("t6_restart_flags", 64'({rdy_d, sv_d, busy_d}), 64'b101);

    // Asynchronous reset part way through a run.
    for (int x = 0; x < 10; x++) send(3, ccg_fn(5'(x)));
    chk("t5_cnt10", 64'(cnt_d), 64'd10);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_sig", 64'(sig_d), 64'd0);
    chk("t5_async_cnt", 64'(cnt_d), 64'd0);
    chk("t5_async_flags", 64'({rdy_d, sv_d, busy_d}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    golden_sig = exp_def;
    exp_q.push_back(exp_def);
    do_start(3);
    for (int x = 0; x < 32; x++) send(3, ccg_fn(5'(x)));
    wait_done(3, "t5_rerun");
`ifdef CCG_MISR_GOLDEN_CMP_EN
    chk("t5_pass", 64'(pass_d), 64'd1);
`endif
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
